cas_recorder: RTL and testbench

- Cassette record path: digitises the CoCo 6-bit sound DAC output while the cassette relay is on, demodulates the 1200/2400 Hz FSK, assembles bytes and writes them sequentially into the tape RAM.
- Downstream of the coco3fpga sound/relay outputs; upstream of the tape RAM write port, sharing the same CAS image the cassette player reads.
- Produces a CAS-format byte stream: leader, sync and data bytes, LSB-first.

---
 rtl/cas_rec_pkg.sv | 22 ++
 rtl/cas_rec_zc.sv | 106 ++++++++++
 rtl/cas_recorder.sv | 157 +++++++++++++++
 tb/tb_cas_recorder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cas_rec_pkg.sv
// Shared types and default constants for the cassette record path.
package cas_rec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h55;

    localparam int ZC_HI_DEF   = 40;
    localparam int ZC_LO_DEF   = 24;
    localparam int BIT_THR_DEF = 560;
    localparam int GAP_MAX_DEF = 1100;
    localparam int ADDR_W_DEF  = 16;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/cas_rec_zc.sv
// Zero-crossing front end: hysteresis comparator on the DAC level, rising-edge
// period measurement and FSK bit decision. Defining CAS_REC_FILTER_EN adds a
// 3-sample majority vote on the raw threshold decisions ahead of the comparator.
module cas_rec_zc
    import cas_rec_pkg::*;
#(
    parameter int ZC_HI   = ZC_HI_DEF,
    parameter int ZC_LO   = ZC_LO_DEF,
    parameter int BIT_THR = BIT_THR_DEF,
    parameter int GAP_MAX = GAP_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       q_ce,
    input  logic [5:0] dac_in,
    output logic       bit_valid,
    output logic       bit_val,
    output logic       gap
);

    localparam int CNT_W = $clog2(GAP_MAX + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(GAP_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_GAP = CNT_W'(GAP_MAX);
    localparam logic [CNT_W-1:0] THR     = CNT_W'(BIT_THR);
    localparam logic [6:0]       HI_LVL  = 7'(ZC_HI);
    localparam logic [6:0]       LO_LVL  = 7'(ZC_LO);

    logic             hi_raw;
    logic             lo_raw;
    logic             hi_dec;
    logic             lo_dec;
    logic             comp;
    logic             comp_next;
    logic             rise;
    logic             have_edge;
    logic [CNT_W-1:0] period;

    assign hi_raw = ({1'b0, dac_in} >= HI_LVL);
    assign lo_raw = ({1'b0, dac_in} <= LO_LVL);

`ifdef CAS_REC_FILTER_EN
    logic [2:0] hi_hist;
    logic [2:0] lo_hist;

    // Keep the last three raw decisions so isolated spikes get outvoted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_hist <= 3'b000;
            lo_hist <= 3'b000;
        end else if (q_ce) begin
            hi_hist <= {hi_hist[1:0], hi_raw};
            lo_hist <= {lo_hist[1:0], lo_raw};
        end
    end

    assign hi_dec = maj3(hi_hist);
    assign lo_dec = maj3(lo_hist);
`else
    assign hi_dec = hi_raw;
    assign lo_dec = lo_raw;
`endif

    // Hysteresis: switch only when a threshold is crossed, otherwise hold
    always_comb begin
        comp_next = comp;
        if (hi_dec)
            comp_next = 1'b1;
        else if (lo_dec)
            comp_next = 1'b0;
    end

    assign rise = q_ce & comp_next & ~comp;

    // Measure rising-edge to rising-edge period and turn it into a bit or a gap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            comp      <= 1'b0;
            have_edge <= 1'b0;
            period    <= '0;
            bit_valid <= 1'b0;
            bit_val   <= 1'b0;
            gap       <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            gap       <= 1'b0;
            if (q_ce) begin
                comp <= comp_next;
                if (rise) begin
                    if (have_edge) begin
                        bit_valid <= 1'b1;
                        bit_val   <= (period < THR);
                    end
                    have_edge <= 1'b1;
                    period    <= CNT_W'(1);
                end else if (period != CNT_SAT) begin
                    period <= period + CNT_W'(1);
                    if (period == CNT_GAP) begin
                        gap       <= 1'b1;
                        have_edge <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cas_recorder.sv
// Cassette record path top: byte alignment FSM, bit shift register and the
// single-entry holding register feeding the tape RAM write port.
// Optional input filter is enabled with CAS_REC_FILTER_EN (see cas_rec_zc).
module cas_recorder
    import cas_rec_pkg::*;
#(
    parameter int ZC_HI   = ZC_HI_DEF,
    parameter int ZC_LO   = ZC_LO_DEF,
    parameter int BIT_THR = BIT_THR_DEF,
    parameter int GAP_MAX = GAP_MAX_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              q_ce,
    input  logic [5:0]        dac_in,
    input  logic              motor,
    input  logic              arm,
    input  logic              clear,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] byte_count,
    output logic              locked,
    output logic              full,
    output logic              overflow
);

    logic       bit_valid;
    logic       bit_val;
    logic       gap;
    state_t     state;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic [2:0] bit_cnt;
    logic       queue_valid;
    logic [7:0] queue_data;
    logic       xfer;
    logic       last_addr;
    logic       full_now;

    cas_rec_zc #(
        .ZC_HI   (ZC_HI),
        .ZC_LO   (ZC_LO),
        .BIT_THR (BIT_THR),
        .GAP_MAX (GAP_MAX)
    ) u_zc (
        .clk       (clk),
        .reset     (reset),
        .q_ce      (q_ce),
        .dac_in    (dac_in),
        .bit_valid (bit_valid),
        .bit_val   (bit_val),
        .gap       (gap)
    );

    // Bits arrive LSB first, so each new bit enters at the top
    assign shift_next = {bit_val, shift_reg[7:1]};

    // Alignment FSM: hunt for the sync byte, then frame every 8 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= 8'h00;
            bit_cnt     <= 3'd0;
            locked      <= 1'b0;
            queue_valid <= 1'b0;
            queue_data  <= 8'h00;
        end else begin
            queue_valid <= 1'b0;
            if (!(motor && arm)) begin
                state     <= IDLE;
                locked    <= 1'b0;
                bit_cnt   <= 3'd0;
                shift_reg <= 8'h00;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= HUNT;
                        shift_reg <= 8'h00;
                        bit_cnt   <= 3'd0;
                    end
                    HUNT: begin
                        if (bit_valid) begin
                            shift_reg <= shift_next;
                            if (shift_next == SYNC_BYTE) begin
                                queue_valid <= 1'b1;
                                queue_data  <= shift_next;
                                locked      <= 1'b1;
                                bit_cnt     <= 3'd0;
                                state       <= LOCKED;
                            end
                        end
                    end
                    LOCKED: begin
                        if (gap) begin
                            state     <= HUNT;
                            locked    <= 1'b0;
                            bit_cnt   <= 3'd0;
                            shift_reg <= 8'h00;
                        end else if (bit_valid) begin
                            shift_reg <= shift_next;
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                queue_valid <= 1'b1;
                                queue_data  <= shift_next;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign xfer      = wr_valid & wr_ready;
    assign last_addr = &wr_addr;
    assign full_now  = full | (xfer & last_addr);

    // Holding register and address bookkeeping; byte_count saturates like the address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
            byte_count <= '0;
            full       <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            byte_count <= '0;
            full       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (xfer) begin
                wr_valid <= 1'b0;
                if (last_addr)
                    full <= 1'b1;
                else
                    wr_addr <= wr_addr + ADDR_W'(1);
                if (!(&byte_count))
                    byte_count <= byte_count + ADDR_W'(1);
            end
            if (queue_valid && !full_now) begin
                if (wr_valid && !xfer) begin
                    overflow <= 1'b1;
                end else begin
                    wr_valid <= 1'b1;
                    wr_data  <= queue_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_cas_recorder.sv
// Directed bench for cas_recorder built with a 4-bit address space so the full
// condition is reachable; written bytes are matched against a scoreboard queue.
module tb_cas_recorder;
    import cas_rec_pkg::*;

    localparam int AW = 4;
    localparam int P1 = 373;
    localparam int P0 = 746;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          q_ce = 1'b1;
    logic [5:0]    dac_in = 6'd0;
    logic          motor = 1'b0;
    logic          arm = 1'b0;
    logic          clear = 1'b0;
    logic          wr_ready = 1'b1;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] byte_count;
    logic          locked;
    logic          full;
    logic          overflow;

    int tests_run = 0;
    int tests_failed = 0;
    int bit_pulses = 0;
    logic [AW+7:0] exp_q[$];

    always #5 clk = ~clk;

    cas_recorder #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .q_ce       (q_ce),
        .dac_in     (dac_in),
        .motor      (motor),
        .arm        (arm),
        .clear      (clear),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .byte_count (byte_count),
        .locked     (locked),
        .full       (full),
        .overflow   (overflow)
    );

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Hold a DAC level for a number of clocks (q_ce is high every clock)
    task automatic applyStimulus(input logic [5:0] level, input int ticks);
        dac_in = level;
        repeat (ticks) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One square-wave cycle; its length encodes one bit
    task automatic send_bit(input logic b);
        int p;
        p = b ? P1 : P0;
        applyStimulus(6'd63, p / 2);
        applyStimulus(6'd0, p - p / 2);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++)
            send_bit(b[i]);
    endtask

    task automatic expect_write(input int addr, input logic [7:0] data);
        exp_q.push_back({AW'(addr), data});
    endtask

    // Scoreboard monitor: every RAM handshake must match the next expected entry
    always @(negedge clk) begin
        logic [AW+7:0] e;
        if (dut.u_zc.bit_valid === 1'b1)
            bit_pulses++;
        if (reset === 1'b0 && wr_valid === 1'b1 && wr_ready === 1'b1) begin
            tests_run++;
            assert (exp_q.size() > 0) else begin
                tests_failed++;
                $error("[TB] FAIL unexpected_write: observed addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("write_addr", 32'(wr_addr), 32'(e[AW+7:8]));
                checkOutput("write_data", 32'(wr_data), 32'(e[7:0]));
            end
        end
    end

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("rst_wr_valid", 32'(wr_valid), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_byte_count", 32'(byte_count), 32'd0);
        checkOutput("rst_locked", 32'(locked), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_state", 32'(dut.state), 32'(IDLE));

        motor = 1'b1;
        arm   = 1'b1;
        applyStimulus(6'd0, 10);
        checkOutput("hunt_state", 32'(dut.state), 32'(HUNT));

        // Levels inside the hysteresis band must never produce edges
        for (int i = 0; i < 20; i++) begin
            applyStimulus(6'd30, 5);
            applyStimulus(6'd36, 5);
        end
        checkOutput("hyst_bits", 32'(bit_pulses), 32'd0);
        checkOutput("hyst_comp", 32'(dut.u_zc.comp), 32'd0);
        applyStimulus(6'd0, 20);

        // Sync, data byte, then fill the address space
        for (int a = 0; a < 4; a++)
            expect_write(a, 8'h55);
        expect_write(4, 8'hA7);
        for (int a = 5; a < 16; a++)
            expect_write(a, 8'hFF);

        send_byte(8'h55);
        send_byte(8'h55);
        checkOutput("locked_after_sync", 32'(locked), 32'd1);
        send_byte(8'h55);
        send_byte(8'h55);
        send_byte(8'hA7);
        send_byte(8'hFF);
        checkOutput("count_after_a7", 32'(byte_count), 32'd5);
        checkOutput("addr_after_a7", 32'(wr_addr), 32'd5);
        for (int i = 0; i < 10; i++)
            send_byte(8'hFF);
        send_byte(8'hFF);
        checkOutput("full_set", 32'(full), 32'd1);
        checkOutput("addr_no_wrap", 32'(wr_addr), 32'd15);
        send_byte(8'hFF);
        checkOutput("full_discard_valid", 32'(wr_valid), 32'd0);
        checkOutput("full_discard_overflow", 32'(overflow), 32'd0);
        checkOutput("full_writes_done", 32'(exp_q.size()), 32'd0);

        // Clear, then backpressure on the first byte after it
        clear    = 1'b1;
        wr_ready = 1'b0;
        @(posedge clk);
        #1 clear = 1'b0;
        checkOutput("clear_full", 32'(full), 32'd0);
        checkOutput("clear_count", 32'(byte_count), 32'd0);
        checkOutput("clear_addr", 32'(wr_addr), 32'd0);
        checkOutput("clear_locked", 32'(locked), 32'd1);
        expect_write(0, 8'hFF);
        send_byte(8'hFF);
        checkOutput("held_valid", 32'(wr_valid), 32'd1);
        checkOutput("held_addr", 32'(wr_addr), 32'd0);
        checkOutput("held_data", 32'(wr_data), 32'hFF);
        checkOutput("held_overflow", 32'(overflow), 32'd0);
        send_byte(8'hFF);
        checkOutput("drop_overflow", 32'(overflow), 32'd1);
        checkOutput("drop_count", 32'(byte_count), 32'd0);
        checkOutput("drop_valid", 32'(wr_valid), 32'd1);
        wr_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("release_count", 32'(byte_count), 32'd1);
        checkOutput("release_addr", 32'(wr_addr), 32'd1);
        checkOutput("release_valid", 32'(wr_valid), 32'd0);

        // Signal loss drops alignment; a non-sync byte then writes nothing
        applyStimulus(6'd32, 1200);
        checkOutput("gap_locked", 32'(locked), 32'd0);
        checkOutput("gap_state", 32'(dut.state), 32'(HUNT));
        send_byte(8'h12);
        send_bit(1'b1);
        applyStimulus(6'd0, 20);
        checkOutput("nosync_count", 32'(byte_count), 32'd1);
        checkOutput("nosync_valid", 32'(wr_valid), 32'd0);
        checkOutput("nosync_locked", 32'(locked), 32'd0);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
